alu_arbiter: RTL and testbench

Two-port arbiter that shares the single 32-bit `ALU` datapath between two requesters, such as the decode stage and the address-generation unit. It accepts operations over a valid/ready handshake, picks a winner round-robin, and registers the winning operands into the ALU. It tracks which requester owns each in-flight slot and returns the ALU result and flags to that requester as a one-cycle response pulse. It sits directly in front of `ALU` and owns every ALU input.

---
 rtl/alu_arb_pkg.sv | 22 ++
 rtl/alu_arb_rr2.sv | 52 +++++
 rtl/alu_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: owner encoding, response tag type and default widths shared by the alu_arbiter slice.
package alu_arb_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_OP_W   = 4;
    localparam int ALU_FLAG_W = 4;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

    function automatic owner_e otherOwner(input owner_e o);
        return (o == REQ0) ? REQ1 : REQ0;
    endfunction

endpackage

// File: rtl/alu_arb_rr2.sv
// alu_arb_rr2: two-way round-robin grant logic and the priority pointer it owns.
module alu_arb_rr2
    import alu_arb_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic valid0_i,
    input  logic valid1_i,
    output logic grant0_o,
    output logic grant1_o
);

    owner_e prio_q;
    owner_e prio_d;
    logic   grant0;
    logic   grant1;

    // A lone requester always wins; the pointer only breaks ties.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (en_i) begin
            if (valid0_i && valid1_i) begin
                grant0 = (prio_q == REQ0);
                grant1 = (prio_q == REQ1);
            end else begin
                grant0 = valid0_i;
                grant1 = valid1_i;
            end
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (grant0 || grant1) begin
            prio_d = otherOwner(grant1 ? REQ1 : REQ0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= REQ0;
        end else begin
            prio_q <= prio_d;
        end
    end

    assign grant0_o = grant0;
    assign grant1_o = grant1;

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters, returning tagged results in issue order.
// Build macro ALU_ARB_PERF_EN adds the Perf0Grants/Perf1Grants/PerfConflicts counters.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W  = ALU_DATA_W,
    parameter int OP_W    = ALU_OP_W,
    parameter int FLAG_W  = ALU_FLAG_W,
    parameter int ALU_LAT = 1
) (
    input  logic              Clk,
    input  logic              Reset_n,

    input  logic              Req0Valid,
    output logic              Req0Ready,
    input  logic [DATA_W-1:0] Req0A,
    input  logic [DATA_W-1:0] Req0B,
    input  logic [OP_W-1:0]   Req0Op,
    input  logic              Req0Cin,

    input  logic              Req1Valid,
    output logic              Req1Ready,
    input  logic [DATA_W-1:0] Req1A,
    input  logic [DATA_W-1:0] Req1B,
    input  logic [OP_W-1:0]   Req1Op,
    input  logic              Req1Cin,

    output logic              Rsp0Valid,
    output logic [DATA_W-1:0] Rsp0Result,
    output logic [FLAG_W-1:0] Rsp0Flags,

    output logic              Rsp1Valid,
    output logic [DATA_W-1:0] Rsp1Result,
    output logic [FLAG_W-1:0] Rsp1Flags,

    output logic [DATA_W-1:0] ALUA,
    output logic [DATA_W-1:0] ALUB,
    output logic [OP_W-1:0]   ALUControl,
    output logic              ALUFlagIn,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [FLAG_W-1:0] ALUFlags
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [31:0]       Perf0Grants,
    output logic [31:0]       Perf1Grants,
    output logic [31:0]       PerfConflicts
`endif
);

    localparam int TAG_DEPTH = ALU_LAT + 1;

    logic   run_q;
    logic   grant0;
    logic   grant1;
    logic   grantAny;
    owner_e winner;

    // Reset asserts asynchronously but releases on a clock edge, so the first grant waits one cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    alu_arb_rr2 u_rr2 (
        .clk_i    (Clk),
        .rst_ni   (Reset_n),
        .en_i     (run_q),
        .valid0_i (Req0Valid),
        .valid1_i (Req1Valid),
        .grant0_o (grant0),
        .grant1_o (grant1)
    );

    assign grantAny  = grant0 | grant1;
    assign winner    = grant1 ? REQ1 : REQ0;
    assign Req0Ready = grant0;
    assign Req1Ready = grant1;

    logic [DATA_W-1:0] aluA_q, aluA_d;
    logic [DATA_W-1:0] aluB_q, aluB_d;
    logic [OP_W-1:0]   aluOp_q, aluOp_d;
    logic              aluCin_q, aluCin_d;

    always_comb begin
        aluA_d   = aluA_q;
        aluB_d   = aluB_q;
        aluOp_d  = aluOp_q;
        aluCin_d = aluCin_q;
        if (grant0) begin
            aluA_d   = Req0A;
            aluB_d   = Req0B;
            aluOp_d  = Req0Op;
            aluCin_d = Req0Cin;
        end else if (grant1) begin
            aluA_d   = Req1A;
            aluB_d   = Req1B;
            aluOp_d  = Req1Op;
            aluCin_d = Req1Cin;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            aluA_q   <= '0;
            aluB_q   <= '0;
            aluOp_q  <= '0;
            aluCin_q <= 1'b0;
        end else begin
            aluA_q   <= aluA_d;
            aluB_q   <= aluB_d;
            aluOp_q  <= aluOp_d;
            aluCin_q <= aluCin_d;
        end
    end

    assign ALUA       = aluA_q;
    assign ALUB       = aluB_q;
    assign ALUControl = aluOp_q;
    assign ALUFlagIn  = aluCin_q;

    tag_t [TAG_DEPTH-1:0] tagPipe_q;
    tag_t [TAG_DEPTH-1:0] tagPipe_d;
    tag_t                 tagLast;

    // Entry 0 records every cycle's grant; the last entry lines up with the ALU result.
    always_comb begin
        tagPipe_d    = tagPipe_q;
        tagPipe_d[0] = '{valid: grantAny, owner: winner};
        for (int i = 1; i < TAG_DEPTH; i++) begin
            tagPipe_d[i] = tagPipe_q[i-1];
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tagPipe_q <= '0;
        end else begin
            tagPipe_q <= tagPipe_d;
        end
    end

    assign tagLast = tagPipe_q[TAG_DEPTH-1];

    logic              rsp0Hit;
    logic              rsp1Hit;
    logic [DATA_W-1:0] rsp0Result_q;
    logic [DATA_W-1:0] rsp1Result_q;
    logic [FLAG_W-1:0] rsp0Flags_q;
    logic [FLAG_W-1:0] rsp1Flags_q;

    assign rsp0Hit = tagLast.valid && (tagLast.owner == REQ0);
    assign rsp1Hit = tagLast.valid && (tagLast.owner == REQ1);

    // Results pass straight through in the pulse cycle and are held for the owner afterwards.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rsp0Result_q <= '0;
            rsp0Flags_q  <= '0;
            rsp1Result_q <= '0;
            rsp1Flags_q  <= '0;
        end else begin
            rsp0Result_q <= Rsp0Result;
            rsp0Flags_q  <= Rsp0Flags;
            rsp1Result_q <= Rsp1Result;
            rsp1Flags_q  <= Rsp1Flags;
        end
    end

    assign Rsp0Valid  = rsp0Hit;
    assign Rsp0Result = rsp0Hit ? ALUResult : rsp0Result_q;
    assign Rsp0Flags  = rsp0Hit ? ALUFlags  : rsp0Flags_q;
    assign Rsp1Valid  = rsp1Hit;
    assign Rsp1Result = rsp1Hit ? ALUResult : rsp1Result_q;
    assign Rsp1Flags  = rsp1Hit ? ALUFlags  : rsp1Flags_q;

`ifdef ALU_ARB_PERF_EN
    logic [31:0] perf0_q;
    logic [31:0] perf1_q;
    logic [31:0] perfConf_q;

    // Free-running wrap-around counters.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            perf0_q    <= '0;
            perf1_q    <= '0;
            perfConf_q <= '0;
        end else begin
            perf0_q    <= perf0_q + {31'b0, grant0};
            perf1_q    <= perf1_q + {31'b0, grant1};
            perfConf_q <= perfConf_q + {31'b0, Req0Valid & Req1Valid};
        end
    end

    assign Perf0Grants   = perf0_q;
    assign Perf1Grants   = perf1_q;
    assign PerfConflicts = perfConf_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vector table plus randomized traffic against a transaction-level model.
module tb_alu_arbiter;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        Req0Valid = 1'b0, Req1Valid = 1'b0;
    logic        Req0Ready, Req1Ready;
    logic [31:0] Req0A = '0, Req0B = '0, Req1A = '0, Req1B = '0;
    logic [3:0]  Req0Op = '0, Req1Op = '0;
    logic        Req0Cin = 1'b0, Req1Cin = 1'b0;
    logic        Rsp0Valid, Rsp1Valid;
    logic [31:0] Rsp0Result, Rsp1Result;
    logic [3:0]  Rsp0Flags, Rsp1Flags;
    logic [31:0] ALUA, ALUB;
    logic [3:0]  ALUControl;
    logic        ALUFlagIn;
    logic [31:0] aluResult = '0;
    logic [3:0]  aluFlags;
`ifdef ALU_ARB_PERF_EN
    logic [31:0] Perf0Grants, Perf1Grants, PerfConflicts;
`endif

    always #5 Clk = ~Clk;

    // One-cycle ALU stub: registered A+B+Cin, flags always zero.
    always @(posedge Clk) aluResult <= ALUA + ALUB + {31'b0, ALUFlagIn};
    assign aluFlags = 4'h0;

    alu_arbiter dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0A(Req0A), .Req0B(Req0B),
        .Req0Op(Req0Op), .Req0Cin(Req0Cin),
        .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1A(Req1A), .Req1B(Req1B),
        .Req1Op(Req1Op), .Req1Cin(Req1Cin),
        .Rsp0Valid(Rsp0Valid), .Rsp0Result(Rsp0Result), .Rsp0Flags(Rsp0Flags),
        .Rsp1Valid(Rsp1Valid), .Rsp1Result(Rsp1Result), .Rsp1Flags(Rsp1Flags),
        .ALUA(ALUA), .ALUB(ALUB), .ALUControl(ALUControl), .ALUFlagIn(ALUFlagIn),
        .ALUResult(aluResult), .ALUFlags(aluFlags)
`ifdef ALU_ARB_PERF_EN
        ,
        .Perf0Grants(Perf0Grants), .Perf1Grants(Perf1Grants), .PerfConflicts(PerfConflicts)
`endif
    );

    typedef struct {
        logic        owner;
        logic [31:0] res;
        int          due;
    } pend_t;

    typedef struct {
        logic        rst;
        logic        v0;
        logic [31:0] a0, b0;
        logic        c0;
        logic        v1;
        logic [31:0] a1, b1;
        logic        c1;
        logic        rdy0, rdy1, rv0, rv1;
        logic [31:0] res;
    } vec_t;

    pend_t       pendQ[$];
    vec_t        vecs[$];
    logic        mPrio = 1'b0;
    logic        running = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          perfAfter = -1;
    logic [31:0] expRes0 = '0, expRes1 = '0, expA = '0, expB = '0;
    logic [3:0]  expOp = '0;
    logic        expCin = 1'b0;
    logic        smpRdy0, smpRdy1, smpRv0, smpRv1;
    logic [31:0] smpRes0, smpRes1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drives one cycle from a negedge, checks against the model, and returns at the next negedge.
    task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                                 input logic [3:0] op0, input logic c0,
                                 input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                                 input logic [3:0] op1, input logic c1);
        logic  g0, g1, e0v, e1v;
        pend_t p;
        Req0Valid = v0; Req0A = a0; Req0B = b0; Req0Op = op0; Req0Cin = c0;
        Req1Valid = v1; Req1A = a1; Req1B = b1; Req1Op = op1; Req1Cin = c1;
        #1;
        g0 = running && v0 && (!v1 || mPrio == 1'b0);
        g1 = running && v1 && (!v0 || mPrio == 1'b1);
        e0v = 1'b0;
        e1v = 1'b0;
        if (pendQ.size() > 0 && pendQ[0].due == cyc) begin
            p = pendQ.pop_front();
            if (p.owner == 1'b0) begin e0v = 1'b1; expRes0 = p.res; end
            else begin e1v = 1'b1; expRes1 = p.res; end
        end
        smpRdy0 = Req0Ready; smpRdy1 = Req1Ready;
        smpRv0 = Rsp0Valid; smpRv1 = Rsp1Valid;
        smpRes0 = Rsp0Result; smpRes1 = Rsp1Result;
        checkOutput("ready0", {31'b0, Req0Ready}, {31'b0, g0});
        checkOutput("ready1", {31'b0, Req1Ready}, {31'b0, g1});
        checkOutput("rsp0Valid", {31'b0, Rsp0Valid}, {31'b0, e0v});
        checkOutput("rsp1Valid", {31'b0, Rsp1Valid}, {31'b0, e1v});
        checkOutput("rsp0Result", Rsp0Result, expRes0);
        checkOutput("rsp1Result", Rsp1Result, expRes1);
        checkOutput("rsp0Flags", {28'b0, Rsp0Flags}, 32'd0);
        checkOutput("rsp1Flags", {28'b0, Rsp1Flags}, 32'd0);
        checkOutput("aluA", ALUA, expA);
        checkOutput("aluB", ALUB, expB);
        checkOutput("aluControl", {28'b0, ALUControl}, {28'b0, expOp});
        checkOutput("aluFlagIn", {31'b0, ALUFlagIn}, {31'b0, expCin});
        if (g0) begin
            p.owner = 1'b0; p.res = a0 + b0 + {31'b0, c0}; p.due = cyc + 2;
            pendQ.push_back(p);
            mPrio = 1'b1;
        end
        if (g1) begin
            p.owner = 1'b1; p.res = a1 + b1 + {31'b0, c1}; p.due = cyc + 2;
            pendQ.push_back(p);
            mPrio = 1'b0;
        end
        @(posedge Clk);
        cyc++;
        if (g0) begin expA = a0; expB = b0; expOp = op0; expCin = c0; end
        if (g1) begin expA = a1; expB = b1; expOp = op1; expCin = c1; end
        @(negedge Clk);
    endtask

    // Asserts reset at a negedge, checks the reset state, then releases and checks the sync cycle.
    task automatic doReset();
        Reset_n = 1'b0;
        Req0Valid = 1'b1;
        Req1Valid = 1'b1;
        pendQ.delete();
        mPrio = 1'b0; running = 1'b0;
        expRes0 = '0; expRes1 = '0; expA = '0; expB = '0; expOp = '0; expCin = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checkOutput("rstReady0", {31'b0, Req0Ready}, 32'd0);
            checkOutput("rstReady1", {31'b0, Req1Ready}, 32'd0);
            checkOutput("rstRsp0Valid", {31'b0, Rsp0Valid}, 32'd0);
            checkOutput("rstRsp1Valid", {31'b0, Rsp1Valid}, 32'd0);
            checkOutput("rstRsp0Result", Rsp0Result, 32'd0);
            checkOutput("rstRsp1Result", Rsp1Result, 32'd0);
            checkOutput("rstAluA", ALUA, 32'd0);
            checkOutput("rstAluB", ALUB, 32'd0);
            checkOutput("rstAluControl", {28'b0, ALUControl}, 32'd0);
            checkOutput("rstAluFlagIn", {31'b0, ALUFlagIn}, 32'd0);
            @(negedge Clk);
        end
        Reset_n = 1'b1;
        applyStimulus(1'b1, 32'd9, 32'd9, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
        running = 1'b1;
    endtask

    function automatic vec_t mk(logic v0, logic [31:0] a0, logic [31:0] b0, logic c0,
                                logic v1, logic [31:0] a1, logic [31:0] b1, logic c1,
                                logic rdy0, logic rdy1, logic rv0, logic rv1, logic [31:0] res);
        vec_t r;
        r.rst = 1'b0;
        r.v0 = v0; r.a0 = a0; r.b0 = b0; r.c0 = c0;
        r.v1 = v1; r.a1 = a1; r.b1 = b1; r.c1 = c1;
        r.rdy0 = rdy0; r.rdy1 = rdy1; r.rv0 = rv0; r.rv1 = rv1; r.res = res;
        return r;
    endfunction

    function automatic vec_t rstRow();
        vec_t r;
        r = mk(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        r.rst = 1'b1;
        return r;
    endfunction

    function automatic vec_t idleRow(logic rv0, logic rv1, logic [31:0] res);
        return mk(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, rv0, rv1, res);
    endfunction

    task automatic buildTable();
        // contention straight out of reset: requester 0 first, then 1
        vecs.push_back(rstRow());
        vecs.push_back(mk(1'b1, 32'd120, 32'd32, 1'b0, 1'b1, 32'd192, 32'd69, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
        vecs.push_back(mk(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd192, 32'd69, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0));
        vecs.push_back(idleRow(1'b1, 1'b0, 32'd152));
        vecs.push_back(idleRow(1'b0, 1'b1, 32'd261));
        vecs.push_back(idleRow(1'b0, 1'b0, 32'd0));
        // sustained contention for 10 cycles, then drain
        vecs.push_back(rstRow());
        for (int k = 0; k < 12; k++) begin
            logic on, even, rspOn, rspEven;
            on = (k < 10);
            even = ((k % 2) == 0);
            rspOn = (k >= 2);
            rspEven = (((k - 2) % 2) == 0);
            vecs.push_back(mk(on, 32'(1000 + k), 32'd1, 1'b0, on, 32'(2000 + k), 32'd2, 1'b0,
                              on && even, on && !even, rspOn && rspEven, rspOn && !rspEven,
                              rspOn ? (rspEven ? 32'(1001 + k - 2) : 32'(2002 + k - 2)) : 32'd0));
        end
        perfAfter = vecs.size() - 1;
        // single request from requester 0
        vecs.push_back(mk(1'b1, 32'd15, 32'd1, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
        vecs.push_back(idleRow(1'b0, 1'b0, 32'd0));
        vecs.push_back(idleRow(1'b1, 1'b0, 32'd17));
        vecs.push_back(idleRow(1'b0, 1'b0, 32'd0));
        // solo burst on requester 1
        for (int k = 0; k < 6; k++) begin
            vecs.push_back(mk(1'b0, 32'd0, 32'd0, 1'b0, k < 4, 32'd123412, 32'd64, 1'b0,
                              1'b0, k < 4, 1'b0, k >= 2, 32'd123476));
        end
        // pointer must be back on requester 0
        vecs.push_back(mk(1'b1, 32'd1, 32'd1, 1'b0, 1'b1, 32'd2, 32'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
        vecs.push_back(mk(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd2, 32'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0));
        vecs.push_back(idleRow(1'b1, 1'b0, 32'd2));
        vecs.push_back(idleRow(1'b0, 1'b1, 32'd4));
        // reset the cycle after a grant: that operation never responds
        vecs.push_back(mk(1'b1, 32'd7, 32'd8, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
        vecs.push_back(rstRow());
        vecs.push_back(idleRow(1'b0, 1'b0, 32'd0));
        vecs.push_back(idleRow(1'b0, 1'b0, 32'd0));
        vecs.push_back(mk(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd5, 32'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0));
        vecs.push_back(idleRow(1'b0, 1'b0, 32'd0));
        vecs.push_back(idleRow(1'b0, 1'b1, 32'd12));
        vecs.push_back(idleRow(1'b0, 1'b0, 32'd0));
    endtask

    initial begin
        logic        rv0, rv1, rc0, rc1;
        logic [31:0] ra0, rb0, ra1, rb1;
        logic [3:0]  rop0, rop1;
        buildTable();
        @(negedge Clk);
        foreach (vecs[i]) begin
            if (vecs[i].rst) begin
                doReset();
            end else begin
                applyStimulus(vecs[i].v0, vecs[i].a0, vecs[i].b0, 4'd0, vecs[i].c0,
                              vecs[i].v1, vecs[i].a1, vecs[i].b1, 4'd1, vecs[i].c1);
                checkOutput($sformatf("vec%0d.ready0", i), {31'b0, smpRdy0}, {31'b0, vecs[i].rdy0});
                checkOutput($sformatf("vec%0d.ready1", i), {31'b0, smpRdy1}, {31'b0, vecs[i].rdy1});
                checkOutput($sformatf("vec%0d.rsp0Valid", i), {31'b0, smpRv0}, {31'b0, vecs[i].rv0});
                checkOutput($sformatf("vec%0d.rsp1Valid", i), {31'b0, smpRv1}, {31'b0, vecs[i].rv1});
                if (vecs[i].rv0) checkOutput($sformatf("vec%0d.rsp0Result", i), smpRes0, vecs[i].res);
                if (vecs[i].rv1) checkOutput($sformatf("vec%0d.rsp1Result", i), smpRes1, vecs[i].res);
            end
`ifdef ALU_ARB_PERF_EN
            if (i == perfAfter) begin
                checkOutput("perf0Grants", Perf0Grants, 32'd5);
                checkOutput("perf1Grants", Perf1Grants, 32'd5);
                checkOutput("perfConflicts", PerfConflicts, 32'd10);
            end
`endif
        end

        for (int n = 0; n < 400; n++) begin
            rv0 = ($urandom_range(0, 9) < 6);
            rv1 = ($urandom_range(0, 9) < 6);
            ra0 = $urandom; rb0 = $urandom; ra1 = $urandom; rb1 = $urandom;
            rop0 = 4'($urandom_range(0, 15)); rop1 = 4'($urandom_range(0, 15));
            rc0 = 1'($urandom_range(0, 1)); rc1 = 1'($urandom_range(0, 1));
            applyStimulus(rv0, ra0, rb0, rop0, rc0, rv1, ra1, rb1, rop1, rc1);
        end
        for (int n = 0; n < 4; n++) begin
            applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
        end
        checkOutput("drainEmpty", 32'(pendQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
